// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, keeps one memory read in flight and
// buffers returned words in a prefetch queue. Build macro FETCH_STATS_EN adds stat counters.
module fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_vld,
    input  logic [15:0] mem_rdata,
    output logic        if_valid,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc,
    input  logic        dec_take,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        halt
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0] stat_redirects,
    output logic [15:0] stat_empty
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_V = (CW + 1)'(DEPTH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    logic [1:0]    state_r;
    logic [15:0]   fetch_pc_r;
    logic [15:0]   req_addr_r;
    logic          kill_r;
    logic          halted_r;
    logic [CW-1:0] count_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [15:0]   pc_mem_r    [DEPTH];
    logic [15:0]   instr_mem_r [DEPTH];

    logic          wait_s;
    logic          space_s;
    logic          issue_s;
    logic          push_s;
    logic          pop_s;
    logic          halted_next_s;
    logic          kill_next_s;
    logic [1:0]    state_next_s;

    // Issue / push / pop decisions; space deliberately ignores a same-cycle pop.
    always_comb begin
        wait_s        = (state_r == ST_WAIT);
        space_s       = (({1'b0, count_r} + {{CW{1'b0}}, wait_s}) < DEPTH_V);
        halted_next_s = halted_r || halt;
        issue_s       = 1'b0;
        if (!rst_n || halted_r || redirect || !space_s) begin
            issue_s = 1'b0;
        end else if (state_r == ST_IDLE) begin
            issue_s = !kill_r;
        end else if (wait_s) begin
            issue_s = mem_vld;
        end else begin
            issue_s = 1'b0;
        end
        push_s = wait_s && mem_vld && !kill_r && !redirect;
        pop_s  = dec_take && (count_r != {CW{1'b0}}) && !redirect;
    end

    // Next-state and kill tracking; a redirect with a read still in flight poisons its response.
    always_comb begin
        state_next_s = state_r;
        kill_next_s  = kill_r;
        case (state_r)
            ST_IDLE: begin
                if (issue_s) begin
                    state_next_s = ST_WAIT;
                end else if (halted_next_s) begin
                    state_next_s = ST_HALTED;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!mem_vld || issue_s) begin
                    state_next_s = ST_WAIT;
                end else if (halted_next_s) begin
                    state_next_s = ST_HALTED;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_HALTED: state_next_s = ST_HALTED;
            default:   state_next_s = ST_IDLE;
        endcase
        if (redirect && wait_s && !mem_vld) begin
            kill_next_s = 1'b1;
        end else if (mem_vld) begin
            kill_next_s = 1'b0;
        end else begin
            kill_next_s = kill_r;
        end
    end

    // Control state, fetch PC and queue pointers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            fetch_pc_r <= RESET_PC;
            req_addr_r <= 16'h0000;
            kill_r     <= (state_r == ST_WAIT) && !mem_vld;
            halted_r   <= 1'b0;
            count_r    <= {CW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            wr_ptr_r   <= {PW{1'b0}};
        end else begin
            state_r  <= state_next_s;
            kill_r   <= kill_next_s;
            halted_r <= halted_next_s;
            if (redirect) begin
                fetch_pc_r <= redirect_pc;
            end else if (issue_s) begin
                fetch_pc_r <= fetch_pc_r + 16'h0001;
            end else begin
                fetch_pc_r <= fetch_pc_r;
            end
            if (issue_s) begin
                req_addr_r <= fetch_pc_r;
            end else begin
                req_addr_r <= req_addr_r;
            end
            if (redirect) begin
                count_r  <= {CW{1'b0}};
                rd_ptr_r <= {PW{1'b0}};
                wr_ptr_r <= {PW{1'b0}};
            end else begin
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + PW'(1);
                end else begin
                    wr_ptr_r <= wr_ptr_r;
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PW'(1);
                end else begin
                    rd_ptr_r <= rd_ptr_r;
                end
                case ({push_s, pop_s})
                    2'b10:   count_r <= count_r + CW'(1);
                    2'b01:   count_r <= count_r - CW'(1);
                    default: count_r <= count_r;
                endcase
            end
        end
    end

    // Queue storage: instruction word tagged with the address it was fetched from.
    always_ff @(posedge clk) begin
        if (push_s) begin
            pc_mem_r[wr_ptr_r]    <= req_addr_r;
            instr_mem_r[wr_ptr_r] <= mem_rdata;
        end else begin
            pc_mem_r[wr_ptr_r]    <= pc_mem_r[wr_ptr_r];
            instr_mem_r[wr_ptr_r] <= instr_mem_r[wr_ptr_r];
        end
    end

    // Memory request strobe and queue head presentation.
    always_comb begin
        mem_req  = issue_s;
        mem_addr = issue_s ? fetch_pc_r : 16'h0000;
        if_valid = (count_r != {CW{1'b0}});
        if (if_valid) begin
            if_instr = instr_mem_r[rd_ptr_r];
            if_pc    = pc_mem_r[rd_ptr_r];
        end else begin
            if_instr = 16'h0000;
            if_pc    = 16'h0000;
        end
    end

`ifdef FETCH_STATS_EN
    logic [15:0] stat_redirects_r;
    logic [15:0] stat_empty_r;

    // Saturating counters of redirect cycles and starved (non-halted) cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_redirects_r <= 16'h0000;
            stat_empty_r     <= 16'h0000;
        end else begin
            if (redirect && (stat_redirects_r != 16'hFFFF)) begin
                stat_redirects_r <= stat_redirects_r + 16'h0001;
            end else begin
                stat_redirects_r <= stat_redirects_r;
            end
            if (!if_valid && !halted_r && (stat_empty_r != 16'hFFFF)) begin
                stat_empty_r <= stat_empty_r + 16'h0001;
            end else begin
                stat_empty_r <= stat_empty_r;
            end
        end
    end

    assign stat_redirects = stat_redirects_r;
    assign stat_empty     = stat_empty_r;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: behavioural variable-latency memory plus a
// scoreboard of expected {pc, instr} entries compared whenever the queue head is visible.
module tb_fetch_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_vld;
    logic [15:0] mem_rdata;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic        dec_take;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt;

    logic        w_mem_req;
    logic [15:0] w_mem_addr;
    logic        w_mem_vld;
    logic [15:0] w_mem_rdata;
    logic        w_if_valid;
    logic [15:0] w_if_instr;
    logic [15:0] w_if_pc;

    always #5 clk = ~clk;

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_vld(mem_vld), .mem_rdata(mem_rdata),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .dec_take(dec_take), .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt)
    );

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(16'hFFFE)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .mem_req(w_mem_req), .mem_addr(w_mem_addr), .mem_vld(w_mem_vld), .mem_rdata(w_mem_rdata),
        .if_valid(w_if_valid), .if_instr(w_if_instr), .if_pc(w_if_pc),
        .dec_take(1'b1), .redirect(1'b0), .redirect_pc(16'h0000), .halt(1'b0)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          lat = 1;
    int          cyc = 0;
    logic        pend = 1'b0;
    logic        pend_kill = 1'b0;
    int          pend_rem = 0;
    logic [15:0] pend_addr = 16'h0000;
    logic        halted_m = 1'b0;
    logic [31:0] exp_q[$];
    logic [15:0] req_addr_log[$];
    int          req_cyc_log[$];
    int          n_pops = 0;
    int          first_valid_cyc = -1;
    logic        watch_first = 1'b0;
    logic [15:0] first_pc = 16'h0000;
    logic        req_now = 1'b0;
    logic [15:0] req_now_addr = 16'h0000;
    logic        w_pend = 1'b0;
    logic [15:0] w_pend_addr = 16'h0000;
    logic [15:0] w_log[$];
    logic        w_valid_c2 = 1'b0;
    logic [15:0] w_pc_c2 = 16'h0000;
    logic [15:0] w_instr_c2 = 16'h0000;

    // One clock cycle: drive memory responses, sample at negedge+1, update scoreboard.
    task automatic tick();
        logic        rsp;
        logic        rsp_kill;
        logic [15:0] rsp_addr;
        rsp = 1'b0; rsp_kill = 1'b0; rsp_addr = 16'h0000;
        mem_vld = 1'b0; mem_rdata = 16'h0000;
        if (pend) begin
            if (pend_rem <= 1) begin
                rsp = 1'b1; rsp_kill = pend_kill; rsp_addr = pend_addr; pend = 1'b0;
                mem_vld = 1'b1; mem_rdata = pend_addr ^ 16'hA500;
            end else begin
                pend_rem = pend_rem - 1;
            end
        end
        w_mem_vld   = w_pend;
        w_mem_rdata = w_pend ? (w_pend_addr ^ 16'hA500) : 16'h0000;
        w_pend      = 1'b0;
        req_now     = 1'b0;
        #1;
        if (rst_n === 1'b1) begin
            n_checks++;
            if (if_valid !== (exp_q.size() != 0)) begin
                n_errors++;
                $display("FAIL if_valid cyc %0d: got %b expected %b", cyc, if_valid, exp_q.size() != 0);
            end
            if (exp_q.size() != 0) begin
                n_checks++;
                if ({if_pc, if_instr} !== exp_q[0]) begin
                    n_errors++;
                    $display("FAIL head cyc %0d: got pc %h instr %h expected pc %h instr %h",
                             cyc, if_pc, if_instr, exp_q[0][31:16], exp_q[0][15:0]);
                end
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (watch_first) begin
                    first_pc = if_pc;
                    watch_first = 1'b0;
                end
                if (dec_take && !redirect) begin
                    void'(exp_q.pop_front());
                    n_pops++;
                end
            end else begin
                n_checks++;
                if ((if_pc !== 16'h0000) || (if_instr !== 16'h0000)) begin
                    n_errors++;
                    $display("FAIL empty_head cyc %0d: got pc %h instr %h expected 0000 0000", cyc, if_pc, if_instr);
                end
            end
            if (redirect) begin
                exp_q.delete();
                if (pend) pend_kill = 1'b1;
            end
            if (mem_req === 1'b1) begin
                n_checks++;
                if (pend || redirect || halted_m) begin
                    n_errors++;
                    $display("FAIL illegal_req cyc %0d: got req addr %h expected none (pend %b redirect %b halted %b)",
                             cyc, mem_addr, pend, redirect, halted_m);
                end
                req_addr_log.push_back(mem_addr);
                req_cyc_log.push_back(cyc);
                req_now = 1'b1; req_now_addr = mem_addr;
                pend = 1'b1; pend_rem = lat; pend_addr = mem_addr; pend_kill = 1'b0;
            end
            if (rsp && !rsp_kill && !redirect) exp_q.push_back({rsp_addr, rsp_addr ^ 16'hA500});
            if (halt) halted_m = 1'b1;
            n_checks++;
            if (exp_q.size() > DEPTH) begin
                n_errors++;
                $display("FAIL overflow cyc %0d: got %0d entries expected at most %0d", cyc, exp_q.size(), DEPTH);
            end
            if (w_mem_req === 1'b1) begin
                w_log.push_back(w_mem_addr);
                w_pend = 1'b1; w_pend_addr = w_mem_addr;
            end
            if (cyc == 2) begin
                w_valid_c2 = w_if_valid; w_pc_c2 = w_if_pc; w_instr_c2 = w_if_instr;
            end
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_hold();
        dec_take = 1'b0; redirect = 1'b0; halt = 1'b0; redirect_pc = 16'h0000;
        for (int k = 0; k < 100 && pend; k++) tick();
        if (pend) begin
            n_errors++;
            $display("FAIL drain_timeout: got outstanding request expected none");
        end
        rst_n = 1'b0;
        repeat (3) tick();
        exp_q.delete(); req_addr_log.delete(); req_cyc_log.delete(); w_log.delete();
        pend = 1'b0; w_pend = 1'b0; halted_m = 1'b0; n_pops = 0; first_valid_cyc = -1;
        watch_first = 1'b0;
    endtask

    task automatic reset_release();
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic test_reset();
        reset_hold();
        #1;
        n_checks += 4;
        if (mem_req !== 1'b0)        begin n_errors++; $display("FAIL rst_mem_req: got %b expected 0", mem_req); end
        if (if_valid !== 1'b0)       begin n_errors++; $display("FAIL rst_if_valid: got %b expected 0", if_valid); end
        if (if_instr !== 16'h0000)   begin n_errors++; $display("FAIL rst_if_instr: got %h expected 0000", if_instr); end
        if (if_pc !== 16'h0000)      begin n_errors++; $display("FAIL rst_if_pc: got %h expected 0000", if_pc); end
        reset_release();
    endtask

    task automatic test_stream();
        reset_hold(); reset_release();
        lat = 1; dec_take = 1'b1;
        repeat (10) tick();
        n_checks++;
        if (req_addr_log.size() != 10) begin
            n_errors++; $display("FAIL stream_reqs: got %0d expected 10", req_addr_log.size());
        end
        for (int i = 0; i < req_addr_log.size(); i++) begin
            n_checks++;
            if ((req_addr_log[i] !== 16'(i)) || (req_cyc_log[i] != i)) begin
                n_errors++;
                $display("FAIL stream_addr %0d: got %h at cyc %0d expected %h at cyc %0d",
                         i, req_addr_log[i], req_cyc_log[i], 16'(i), i);
            end
        end
        n_checks += 2;
        if (first_valid_cyc != 2) begin n_errors++; $display("FAIL stream_latency: got %0d expected 2", first_valid_cyc); end
        if (n_pops != 8)          begin n_errors++; $display("FAIL stream_pops: got %0d expected 8", n_pops); end
    endtask

    task automatic test_wrap();
        reset_hold(); reset_release();
        lat = 1;
        repeat (6) tick();
        n_checks++;
        if (w_log.size() < 4) begin
            n_errors++; $display("FAIL wrap_reqs: got %0d expected at least 4", w_log.size());
        end else begin
            n_checks += 4;
            if (w_log[0] !== 16'hFFFE) begin n_errors++; $display("FAIL wrap_a0: got %h expected FFFE", w_log[0]); end
            if (w_log[1] !== 16'hFFFF) begin n_errors++; $display("FAIL wrap_a1: got %h expected FFFF", w_log[1]); end
            if (w_log[2] !== 16'h0000) begin n_errors++; $display("FAIL wrap_a2: got %h expected 0000", w_log[2]); end
            if (w_log[3] !== 16'h0001) begin n_errors++; $display("FAIL wrap_a3: got %h expected 0001", w_log[3]); end
        end
        n_checks++;
        if ({w_valid_c2, w_pc_c2, w_instr_c2} !== {1'b1, 16'hFFFE, 16'h5AFE}) begin
            n_errors++;
            $display("FAIL wrap_head: got %b %h %h expected 1 FFFE 5AFE", w_valid_c2, w_pc_c2, w_instr_c2);
        end
    endtask

    task automatic test_backpressure();
        reset_hold(); reset_release();
        lat = 1; dec_take = 1'b0;
        repeat (10) tick();
        n_checks++;
        if (req_addr_log.size() != 4) begin
            n_errors++; $display("FAIL bp_reqs: got %0d expected 4", req_addr_log.size());
        end
        for (int i = 0; i < req_addr_log.size(); i++) begin
            n_checks++;
            if (req_addr_log[i] !== 16'(i)) begin
                n_errors++; $display("FAIL bp_addr %0d: got %h expected %h", i, req_addr_log[i], 16'(i));
            end
        end
        n_checks++;
        if ({if_valid, if_pc} !== {1'b1, 16'h0000}) begin
            n_errors++; $display("FAIL bp_hold: got %b %h expected 1 0000", if_valid, if_pc);
        end
        dec_take = 1'b1; tick(); dec_take = 1'b0;
        repeat (6) tick();
        n_checks++;
        if (req_addr_log.size() != 5) begin
            n_errors++; $display("FAIL bp_one_more: got %0d requests expected 5", req_addr_log.size());
        end else begin
            n_checks++;
            if (req_addr_log[4] !== 16'h0004) begin
                n_errors++; $display("FAIL bp_addr4: got %h expected 0004", req_addr_log[4]);
            end
        end
    endtask

    task automatic test_redirect_kill();
        logic found;
        int   n_before;
        int   rcyc;
        reset_hold(); reset_release();
        lat = 3; found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            dec_take = (cyc % 2 == 0) ? 1'b1 : 1'b0;
            tick();
            if (req_now && (req_now_addr == 16'h0005)) found = 1'b1;
        end
        n_checks++;
        if (!found) begin n_errors++; $display("FAIL rk_timeout: got no request for 0005 expected one"); end
        dec_take = 1'b1; redirect = 1'b1; redirect_pc = 16'h0040;
        n_before = req_addr_log.size(); rcyc = cyc;
        tick();
        redirect = 1'b0; watch_first = 1'b1;
        repeat (12) tick();
        n_checks++;
        if (req_addr_log.size() <= n_before) begin
            n_errors++; $display("FAIL rk_restart: got no request expected 0040");
        end else begin
            n_checks++;
            if ((req_addr_log[n_before] !== 16'h0040) || (req_cyc_log[n_before] != rcyc + 2)) begin
                n_errors++;
                $display("FAIL rk_first_req: got %h at cyc %0d expected 0040 at cyc %0d",
                         req_addr_log[n_before], req_cyc_log[n_before], rcyc + 2);
            end
        end
        n_checks++;
        if ((watch_first !== 1'b0) || (first_pc !== 16'h0040)) begin
            n_errors++; $display("FAIL rk_first_pc: got %h (pending %b) expected 0040", first_pc, watch_first);
        end
    endtask

    task automatic test_redirect_vld();
        logic found;
        int   n_before;
        int   rcyc;
        reset_hold(); reset_release();
        lat = 1; dec_take = 1'b1; found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            tick();
            if (req_now && (req_now_addr == 16'h0007)) found = 1'b1;
        end
        n_checks++;
        if (!found) begin n_errors++; $display("FAIL rv_timeout: got no request for 0007 expected one"); end
        redirect = 1'b1; redirect_pc = 16'h0100;
        n_before = req_addr_log.size(); rcyc = cyc;
        tick();
        redirect = 1'b0; watch_first = 1'b1;
        repeat (6) tick();
        n_checks++;
        if (req_addr_log.size() <= n_before) begin
            n_errors++; $display("FAIL rv_restart: got no request expected 0100");
        end else begin
            n_checks++;
            if ((req_addr_log[n_before] !== 16'h0100) || (req_cyc_log[n_before] != rcyc + 1)) begin
                n_errors++;
                $display("FAIL rv_first_req: got %h at cyc %0d expected 0100 at cyc %0d",
                         req_addr_log[n_before], req_cyc_log[n_before], rcyc + 1);
            end
        end
        n_checks++;
        if ((watch_first !== 1'b0) || (first_pc !== 16'h0100)) begin
            n_errors++; $display("FAIL rv_first_pc: got %h (pending %b) expected 0100", first_pc, watch_first);
        end
    endtask

    task automatic test_halt();
        logic found;
        int   n_req;
        reset_hold(); reset_release();
        lat = 3; dec_take = 1'b0; found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            tick();
            if (req_now && (req_now_addr == 16'h0003)) found = 1'b1;
        end
        n_checks++;
        if (!found) begin n_errors++; $display("FAIL halt_timeout: got no request for 0003 expected one"); end
        dec_take = 1'b1; tick();
        halt = 1'b1; n_req = req_addr_log.size(); n_pops = 0;
        tick();
        halt = 1'b0;
        repeat (10) tick();
        n_checks += 3;
        if (n_pops != 3)                     begin n_errors++; $display("FAIL halt_drain: got %0d expected 3", n_pops); end
        if (req_addr_log.size() != n_req)    begin n_errors++; $display("FAIL halt_noreq: got %0d expected %0d", req_addr_log.size(), n_req); end
        if (if_valid !== 1'b0)               begin n_errors++; $display("FAIL halt_empty: got %b expected 0", if_valid); end
        redirect = 1'b1; redirect_pc = 16'h0020; dec_take = 1'b0;
        tick();
        redirect = 1'b0;
        repeat (8) tick();
        n_checks += 2;
        if (req_addr_log.size() != n_req)    begin n_errors++; $display("FAIL halt_redirect: got %0d requests expected %0d", req_addr_log.size(), n_req); end
        if (if_valid !== 1'b0)               begin n_errors++; $display("FAIL halt_redirect_empty: got %b expected 0", if_valid); end
    endtask

    initial begin
        rst_n = 1'b0; dec_take = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000; halt = 1'b0;
        mem_vld = 1'b0; mem_rdata = 16'h0000; w_mem_vld = 1'b0; w_mem_rdata = 16'h0000;
        @(negedge clk);
        test_reset();
        test_stream();
        test_wrap();
        test_backpressure();
        test_redirect_kill();
        test_redirect_vld();
        test_halt();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
